// File: rtl/tex_loader_if.sv
// Byte-stream input and dmem write port shared between the text loader and its environment.
// master = loader side, slave = byte source / memory arbiter side.
interface tex_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_grant;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    modport master (
        input  in_valid, in_data, mem_grant,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output in_valid, in_data, mem_grant,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/tex_loader.sv
// Packs a byte stream little-endian into 32-bit words written sequentially into the text region of dmem.
// Write strobe one cycle after the 4th byte; stalls without accepting bytes while mem_grant is low.
module tex_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned NWORDS    = 2400
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    tex_loader_if.master     bus,
    output logic             busy,
    output logic             done,
    output logic [11:0]      word_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] pack_q, pack_d;
    logic [11:0] word_count_q, word_count_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            lane_q       <= 2'd0;
            pack_q       <= 32'd0;
            word_count_q <= 12'd0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            pack_q       <= pack_d;
            word_count_q <= word_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        lane_d        = lane_q;
        pack_d        = pack_q;
        word_count_d  = word_count_q;
        bus.in_ready  = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = 32'd0;
        bus.mem_wdata = 32'd0;
        busy          = 1'b0;
        done          = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                done = (state_q == S_DONE);
                if (start) begin
                    state_d      = S_FILL;
                    lane_d       = 2'd0;
                    pack_d       = 32'd0;
                    word_count_d = 12'd0;
                end
            end
            S_FILL: begin
                busy         = 1'b1;
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    case (lane_q)
                        2'd0:    pack_d[7:0]   = bus.in_data;
                        2'd1:    pack_d[15:8]  = bus.in_data;
                        2'd2:    pack_d[23:16] = bus.in_data;
                        default: pack_d[31:24] = bus.in_data;
                    endcase
                    lane_d = lane_q + 2'd1;
                    if (lane_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            default: begin
                // S_WRITE: address and data held stable for the whole grant stall
                busy          = 1'b1;
                bus.mem_we    = bus.mem_grant;
                bus.mem_addr  = BASE_ADDR + {18'd0, word_count_q, 2'b00};
                bus.mem_wdata = pack_q;
                if (bus.mem_grant) begin
                    word_count_d = word_count_q + 12'd1;
                    lane_d       = 2'd0;
                    state_d      = (word_count_q == 12'(NWORDS - 1)) ? S_DONE : S_FILL;
                end
            end
        endcase
    end

    assign word_count = word_count_q;

endmodule

// File: tb/tb_tex_loader.sv
// Bench for tex_loader: a byte/word-count model checked every cycle plus directed literal checks.
module tb_tex_loader;
    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam int          NW   = 3;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic [11:0] word_count;

    tex_loader_if bus();

    tex_loader #(.BASE_ADDR(BASE), .NWORDS(NW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Model: a load is a count of accepted bytes and committed words
    bit         m_active  = 1'b0;
    bit         m_done    = 1'b0;
    int         m_nbytes  = 0;
    int         m_nwrites = 0;
    logic [7:0] m_bytes [0:63];
    bit         chk_en    = 1'b0;

    int          wr_cnt = 0;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        int pend;
        chk_en = 1'b1;
        pend = m_nbytes - 4 * m_nwrites;
        if (reset) begin
            m_active = 1'b0; m_done = 1'b0; m_nbytes = 0; m_nwrites = 0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1'b1; m_done = 1'b0; m_nbytes = 0; m_nwrites = 0;
            end
        end else if (pend < 4) begin
            if (bus.in_valid) begin
                m_bytes[m_nbytes] = bus.in_data;
                m_nbytes++;
            end
        end else if (bus.mem_grant) begin
            m_nwrites++;
            if (m_nwrites == NW) begin
                m_active = 1'b0;
                m_done   = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        int pend;
        int w;
        logic [31:0] ew;
        if (chk_en) begin
            pend = m_nbytes - 4 * m_nwrites;
            check("in_ready",   bus.in_ready, (m_active && pend < 4));
            check("mem_we",     bus.mem_we,   (m_active && pend == 4 && bus.mem_grant));
            check("busy",       busy,         m_active);
            check("done",       done,         m_done);
            check("word_count", word_count,   m_nwrites);
            if (m_active && pend == 4) begin
                w  = m_nwrites;
                ew = {m_bytes[4*w+3], m_bytes[4*w+2], m_bytes[4*w+1], m_bytes[4*w]};
                check("mem_addr",  bus.mem_addr,  BASE + 32'(4 * w));
                check("mem_wdata", bus.mem_wdata, ew);
            end
            if (bus.mem_we === 1'b1) begin
                wr_cnt++;
                wr_addr_q.push_back(bus.mem_addr);
                wr_data_q.push_back(bus.mem_wdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        bit r;
        r = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int k = 0; k < 40 && !r; k++) begin
            @(negedge clk);
            r = bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        check("send_handshake", r, 1'b1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.mem_grant = 1'b0;

        // Reset held two cycles with start and in_valid asserted
        tick();
        start = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h5A;
        repeat (2) begin
            @(negedge clk);
            check("rst_in_ready", bus.in_ready, 1'b0);
            check("rst_mem_we",   bus.mem_we,   1'b0);
            check("rst_busy",     busy,         1'b0);
            check("rst_done",     done,         1'b0);
            check("rst_wc",       word_count,   12'd0);
            check("rst_addr",     bus.mem_addr, 32'd0);
            check("rst_wdata",    bus.mem_wdata, 32'd0);
            tick();
        end
        reset = 1'b0; start = 1'b0; bus.in_valid = 1'b0; bus.mem_grant = 1'b1;
        tick();

        // Single word, grant available
        pulse_start();
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        @(negedge clk);
        check("w0_we",    bus.mem_we,    1'b1);
        check("w0_addr",  bus.mem_addr,  32'h0000_0100);
        check("w0_wdata", bus.mem_wdata, 32'h4433_2211);
        tick();
        @(negedge clk);
        check("w0_wc",    word_count,   12'd1);
        check("w0_ready", bus.in_ready, 1'b1);
        tick();

        // Grant stall for 7 cycles
        bus.mem_grant = 1'b0;
        send(8'h55); send(8'h66); send(8'h77); send(8'h88);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("stall_we",    bus.mem_we,    1'b0);
            check("stall_addr",  bus.mem_addr,  32'h0000_0104);
            check("stall_wdata", bus.mem_wdata, 32'h8877_6655);
            check("stall_ready", bus.in_ready,  1'b0);
            tick();
        end
        bus.mem_grant = 1'b1;
        @(negedge clk);
        check("stall_commit", bus.mem_we, 1'b1);
        tick();
        check("stall_wr_cnt", wr_cnt, 2);

        // Last word with gaps and an ignored start pulse
        send(8'h99); idle(3); pulse_start();
        send(8'hAA); idle(1); send(8'hBB); idle(5); send(8'hCC);
        @(negedge clk);
        check("w2_addr",  bus.mem_addr,  32'h0000_0108);
        check("w2_wdata", bus.mem_wdata, 32'hCCBB_AA99);
        tick();
        @(negedge clk);
        check("load1_done", done,       1'b1);
        check("load1_busy", busy,       1'b0);
        check("load1_wc",   word_count, 12'd3);
        check("load1_wr",   wr_cnt,     3);
        tick();
        bus.in_valid = 1'b1; bus.in_data = 8'hEE;
        repeat (4) begin
            @(negedge clk);
            check("done_no_accept", bus.in_ready, 1'b0);
            tick();
        end
        bus.in_valid = 1'b0;

        // Restart from DONE, full load 0x00..0x0B
        wr_addr_q.delete(); wr_data_q.delete();
        pulse_start();
        @(negedge clk);
        check("restart_done", done,       1'b0);
        check("restart_wc",   word_count, 12'd0);
        check("restart_busy", busy,       1'b1);
        tick();
        for (int i = 0; i < 12; i++) begin
            send(8'(i));
            idle(i % 3);
            if (i == 5) pulse_start();
        end
        for (int k = 0; k < 20 && !done; k++) tick();
        check("full_done",   done,       1'b1);
        check("full_wc",     word_count, 12'd3);
        check("full_nwr",    wr_addr_q.size(), 3);
        if (wr_addr_q.size() == 3) begin
            check("full_a0", wr_addr_q[0], 32'h0000_0100);
            check("full_d0", wr_data_q[0], 32'h0302_0100);
            check("full_a1", wr_addr_q[1], 32'h0000_0104);
            check("full_d1", wr_data_q[1], 32'h0706_0504);
            check("full_a2", wr_addr_q[2], 32'h0000_0108);
            check("full_d2", wr_data_q[2], 32'h0B0A_0908);
        end

        // Reset after two bytes discards the partial word
        pulse_start();
        send(8'hD1); send(8'hD2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("midrst_busy",  busy,         1'b0);
        check("midrst_done",  done,         1'b0);
        check("midrst_ready", bus.in_ready, 1'b0);
        check("midrst_wc",    word_count,   12'd0);
        check("midrst_wr",    wr_cnt,       6);
        tick();
        pulse_start();
        send(8'hE1); send(8'hE2); send(8'hE3); send(8'hE4);
        @(negedge clk);
        check("after_rst_we",    bus.mem_we,    1'b1);
        check("after_rst_addr",  bus.mem_addr,  32'h0000_0100);
        check("after_rst_wdata", bus.mem_wdata, 32'hE4E3_E2E1);
        tick();
        check("after_rst_wr", wr_cnt, 7);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
